// File: rtl/inv_sqrt_sequencer.sv
// rtl/inv_sqrt_sequencer.sv - multi-cycle fast inverse square root sequencer driving newtonRaphson
module inv_sqrt_sequencer #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int ITERATIONS  = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] y_out,
    output logic                             zero_err,
    output logic                             busy
);
    localparam int W = INT_WIDTH + FRACT_WIDTH;
    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, SEED, ITER, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   x_reg;
    logic [W-1:0]   x_half_reg;
    logic [W-1:0]   y_reg;
    logic [W-1:0]   seed;
    logic [W-1:0]   nr_y;
    logic           zero_reg;
    logic [3:0]     cnt;
    int             p;
    int             e;
    int             k;
    int             s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SEED;
            SEED:    state_nxt = zero_reg ? DONE : ITER;
            ITER:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        y_out     = y_reg;
        zero_err  = (state == DONE) && zero_reg;
    end

    // Seed is 2^(F - floor((msb - F)/2)), i.e. roughly 1/sqrt(x) to within a factor of two.
    always_comb begin
        p = 0;
        for (int i = 0; i < W; i++) begin
            if (x_reg[i]) p = i;
        end
        e = p - FRACT_WIDTH;
        k = e >>> 1;
        s = FRACT_WIDTH - k;
        if (s < 0) begin
            seed = W'(1);
        end else if (s >= W) begin
            seed = '1;
        end else begin
            seed = W'(1) << s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg      <= '0;
            x_half_reg <= '0;
            y_reg      <= '0;
            zero_reg   <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg      <= x_in;
                        x_half_reg <= x_in >> 1;
                        zero_reg   <= (x_in == '0);
                    end
                end
                SEED: begin
                    y_reg <= zero_reg ? '1 : seed;
                    cnt   <= '0;
                end
                ITER: begin
                    y_reg <= nr_y;
                    cnt   <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    newtonRaphson #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_newton_raphson (
        .y0     (y_reg),
        .x_half (x_half_reg),
        .y      (nr_y)
    );
endmodule

// One Newton-Raphson step y = y0 * (1.5 - x_half * y0^2), truncating each product back to Q format.
module newtonRaphson #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4
) (
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] y0,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_half,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] y
);
    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int PW = 4 * W;
    localparam logic signed [PW-1:0] THREE_HALF = PW'(3) <<< (FRACT_WIDTH - 1);

    logic signed [PW-1:0] y0_w;
    logic signed [PW-1:0] xh_w;
    logic signed [PW-1:0] y_sq;
    logic signed [PW-1:0] t;
    logic signed [PW-1:0] d;
    logic signed [PW-1:0] prod;

    // Negative results clamp to 0 and overflow saturates to all ones.
    always_comb begin
        y0_w = PW'(y0);
        xh_w = PW'(x_half);
        y_sq = (y0_w * y0_w) >>> FRACT_WIDTH;
        t    = (xh_w * y_sq) >>> FRACT_WIDTH;
        d    = THREE_HALF - t;
        prod = (y0_w * d) >>> FRACT_WIDTH;
        if (prod[PW-1]) begin
            y = '0;
        end else if (|prod[PW-2:W]) begin
            y = '1;
        end else begin
            y = prod[W-1:0];
        end
    end
endmodule

// File: tb/tb_inv_sqrt_sequencer.sv
// tb/tb_inv_sqrt_sequencer.sv - self-checking bench for inv_sqrt_sequencer
module tb_inv_sqrt_sequencer;
    localparam int IW = 12;
    localparam int FW = 4;
    localparam int IT = 2;
    localparam int W  = IW + FW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y_out;
    logic         zero_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    inv_sqrt_sequencer #(.INT_WIDTH(IW), .FRACT_WIDTH(FW), .ITERATIONS(IT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .zero_err  (zero_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint seed_of(input longint x);
        int p;
        int e;
        int k;
        int s;
        p = 0;
        for (int i = 0; i < W; i++) if (x >= (64'sd1 <<< i)) p = i;
        e = p - FW;
        k = (e >= 0) ? e / 2 : -((1 - e) / 2);
        s = FW - k;
        if (s < 0) return 1;
        if (s >= W) return (64'sd1 <<< W) - 1;
        return 64'sd1 <<< s;
    endfunction

    function automatic longint nr_pass(input longint y0, input longint xh);
        longint y2;
        longint t;
        longint d;
        longint y;
        y2 = (y0 * y0) >>> FW;
        t  = (xh * y2) >>> FW;
        d  = (3 <<< (FW - 1)) - t;
        y  = (y0 * d) >>> FW;
        if (y < 0) return 0;
        if (y >= (64'sd1 <<< W)) return (64'sd1 <<< W) - 1;
        return y;
    endfunction

    function automatic longint exp_result(input longint x);
        longint y;
        if (x == 0) return (64'sd1 <<< W) - 1;
        y = seed_of(x);
        for (int i = 0; i < IT; i++) y = nr_pass(y, x >>> 1);
        return y;
    endfunction

    // Transaction-level model: checks every output on every falling edge.
    bit     m_pending = 1'b0;
    longint m_y = 0;
    bit     m_z = 1'b0;
    int     m_ready_at = 0;
    int     ncyc = 0;

    always @(negedge clk) begin
        bit exp_valid;
        bit hs;
        bit acc;
        ncyc++;
        if (!rst_n) begin
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_y_out", 64'(y_out), 64'd0);
            check("rst_zero_err", 64'(zero_err), 64'd0);
            m_pending = 1'b0;
        end else begin
            exp_valid = m_pending && (ncyc >= m_ready_at);
            check("mon_in_ready", 64'(in_ready), 64'(!m_pending));
            check("mon_busy", 64'(busy), 64'(m_pending));
            check("mon_out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("mon_y_out", 64'(y_out), 64'(m_y));
                check("mon_zero_err", 64'(zero_err), 64'(m_z));
            end
            acc = !m_pending && in_valid;
            hs  = exp_valid && out_ready;
            if (hs) m_pending = 1'b0;
            if (acc) begin
                m_pending  = 1'b1;
                m_z        = (x_in == '0);
                m_y        = exp_result(longint'(x_in));
                m_ready_at = ncyc + (m_z ? 2 : 2 + IT);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] exp_y, input logic exp_z,
                         input logic [W-1:0] exp_xh, input int hold);
        int waited;
        @(posedge clk); #2;
        check("op_in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        x_in = x;
        out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("op_x_half_reg", 64'(dut.x_half_reg), 64'(exp_xh));
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        check("op_latency", 64'(waited), exp_z ? 64'd1 : 64'(1 + IT));
        check("op_y_out", 64'(y_out), 64'(exp_y));
        check("op_zero_err", 64'(zero_err), 64'(exp_z));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x_in = 16'h0100;
            @(posedge clk); #2;
            check("hold_y_out", 64'(y_out), 64'(exp_y));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_out_valid", 64'(out_valid), 64'd0);
    endtask

    logic [W-1:0] vec [8] = '{16'h0001, 16'h0002, 16'h0100, 16'h1234,
                              16'h8000, 16'h0000, 16'h0003, 16'h7FFF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        check("model_seed_1p0", 64'(seed_of(16'h0010)), 64'h0010);
        check("model_seed_4p0", 64'(seed_of(16'h0040)), 64'h0008);
        check("model_seed_ffff", 64'(seed_of(16'hFFFF)), 64'h0001);
        check("model_res_1p0", 64'(exp_result(16'h0010)), 64'h0010);
        check("model_res_4p0", 64'(exp_result(16'h0040)), 64'h0008);
        check("model_res_0001", 64'(exp_result(16'h0001)), 64'h0090);
        check("model_res_ffff", 64'(exp_result(16'hFFFF)), 64'h0001);

        #13;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        do_op(16'h0010, 16'h0010, 1'b0, 16'h0008, 0);
        do_op(16'h0040, 16'h0008, 1'b0, 16'h0020, 0);
        do_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 0);
        do_op(16'hFFFF, W'(exp_result(16'hFFFF)), 1'b0, 16'h7FFF, 0);
        do_op(16'h0040, 16'h0008, 1'b0, 16'h0020, 5);

        // Reset in the middle of the refinement passes.
        @(posedge clk); #2;
        in_valid = 1'b1;
        x_in = 16'h0040;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        do_op(16'h0010, 16'h0010, 1'b0, 16'h0008, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(vec[i], W'(exp_result(longint'(vec[i]))), vec[i] == '0, vec[i] >> 1, i % 2);
        end

        // Streaming with in_valid and out_ready held high; the monitor checks spacing.
        @(posedge clk); #2;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            x_in = vec[i % 8];
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("final_idle", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
